// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side packer.
package fifo_pkg;

  localparam int unsigned DefaultWidth = 16;

  typedef enum logic {
    FILL,
    FLUSH
  } pack_state_e;

  function automatic int unsigned pack_count_bits(input int unsigned pack);
    return $clog2(pack + 1);
  endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// Single-entry valid/ready holding register; can be reloaded in the cycle it drains.
module fifo_out_slot #(
  parameter int unsigned DW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          slot_free
);

  logic          valid_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= load_data;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign slot_free = !valid_q || out_ready;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains FIFO words and packs PACK of them into one wide beat; flush emits a partial beat.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned PACK     = 2,
  parameter int unsigned CNT_BITS = pack_count_bits(PACK)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic                  fifo_rd_en,
  input  logic [WIDTH-1:0]      fifo_rd_data,
  input  logic                  fifo_rd_valid,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PACK*WIDTH-1:0] out_data,
  output logic [CNT_BITS-1:0]   out_count,
  output logic                  busy
);

  localparam int unsigned IdxW = $clog2(PACK);
  localparam int unsigned DW   = PACK * WIDTH + CNT_BITS;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PACK - 1);

  pack_state_e state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  // Lanes 0..PACK-2 hold words awaiting the final word of a beat.
  logic [PACK-2:0][WIDTH-1:0] lanes_q, lanes_d;
  logic [PACK-2:0][WIDTH-1:0] flush_lanes;

  logic          load;
  logic [DW-1:0] load_data;
  logic [DW-1:0] slot_data;
  logic          slot_free;

  always_comb begin
    flush_lanes = '0;
    for (int unsigned k = 0; k < PACK - 1; k++) begin
      if (IdxW'(k) < idx_q) flush_lanes[k] = lanes_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lanes_d    = lanes_q;
    load       = 1'b0;
    load_data  = '0;
    fifo_rd_en = 1'b0;
    unique case (state_q)
      FILL: begin
        fifo_rd_en = (idx_q != LastIdx) || slot_free;
        if (fifo_rd_valid) begin
          if (idx_q != LastIdx) begin
            for (int unsigned k = 0; k < PACK - 1; k++) begin
              if (idx_q == IdxW'(k)) lanes_d[k] = fifo_rd_data;
            end
            idx_d = idx_q + IdxW'(1);
          end else begin
            load      = 1'b1;
            load_data = {CNT_BITS'(PACK), fifo_rd_data, lanes_q};
            idx_d     = '0;
            lanes_d   = '0;
          end
        end
        // Decide on the post-capture fill level so a just-completed beat never
        // produces a trailing empty beat.
        if (flush && idx_d != '0) state_d = FLUSH;
      end
      FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = {CNT_BITS'(idx_q), {WIDTH{1'b0}}, flush_lanes};
          idx_d     = '0;
          lanes_d   = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
    if (!reset_n) fifo_rd_en = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

  fifo_out_slot #(
    .DW(DW)
  ) u_slot (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (slot_data),
    .slot_free (slot_free)
  );

  assign out_data  = slot_data[PACK*WIDTH-1:0];
  assign out_count = slot_data[DW-1 -: CNT_BITS];
  assign busy      = (idx_q != '0) || (state_q == FLUSH) || out_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench: directed stimulus for PACK=2 and PACK=4 packers, monitors check beats.
module tb_fifo_rd_packer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;

  // PACK=2 instance
  logic        rd_en2, rd_valid2 = 1'b0, flush2 = 1'b0, out_valid2, out_ready2 = 1'b1, busy2;
  logic [15:0] rd_data2 = '0;
  logic [31:0] out_data2;
  logic [1:0]  out_count2;
  // PACK=4 instance
  logic        rd_en4, rd_valid4 = 1'b0, flush4 = 1'b0, out_valid4, out_ready4 = 1'b1, busy4;
  logic [15:0] rd_data4 = '0;
  logic [63:0] out_data4;
  logic [2:0]  out_count4;

  logic [63:0] q2_data[$], q4_data[$];
  int          q2_cnt[$], q4_cnt[$];

  fifo_rd_packer #(.WIDTH(16), .PACK(2)) u_p2 (
    .clock(clock), .reset_n(reset_n), .fifo_rd_en(rd_en2), .fifo_rd_data(rd_data2),
    .fifo_rd_valid(rd_valid2), .flush(flush2), .out_valid(out_valid2),
    .out_ready(out_ready2), .out_data(out_data2), .out_count(out_count2), .busy(busy2)
  );

  fifo_rd_packer #(.WIDTH(16), .PACK(4)) u_p4 (
    .clock(clock), .reset_n(reset_n), .fifo_rd_en(rd_en4), .fifo_rd_data(rd_data4),
    .fifo_rd_valid(rd_valid4), .flush(flush4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .out_count(out_count4), .busy(busy4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every accepted beat; also police the read protocol.
  always @(negedge clock) begin
    if (reset_n) begin
      if (rd_valid2) check("p2_rd_protocol", 64'(rd_en2), 64'd1);
      if (rd_valid4) check("p4_rd_protocol", 64'(rd_en4), 64'd1);
      if (out_valid2 && out_ready2) begin
        if (q2_data.size() == 0) check("p2_unexpected_beat", 64'(out_data2), 64'hx);
        else begin
          check("p2_beat_data", 64'(out_data2), q2_data.pop_front());
          check("p2_beat_count", 64'(out_count2), 64'(q2_cnt.pop_front()));
        end
      end
      if (out_valid4 && out_ready4) begin
        if (q4_data.size() == 0) check("p4_unexpected_beat", out_data4, 64'hx);
        else begin
          check("p4_beat_data", out_data4, q4_data.pop_front());
          check("p4_beat_count", 64'(out_count4), 64'(q4_cnt.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push2(input logic [15:0] w, input logic fl);
    int n = 0;
    while (!rd_en2 && n < 50) begin tick(); n++; end
    check("p2_rd_en_wait", 64'(rd_en2), 64'd1);
    rd_valid2 = 1'b1; rd_data2 = w; flush2 = fl;
    tick();
    rd_valid2 = 1'b0; flush2 = 1'b0;
  endtask

  task automatic push4(input logic [15:0] w);
    int n = 0;
    while (!rd_en4 && n < 50) begin tick(); n++; end
    check("p4_rd_en_wait", 64'(rd_en4), 64'd1);
    rd_valid4 = 1'b1; rd_data4 = w;
    tick();
    rd_valid4 = 1'b0;
  endtask

  task automatic exp2(input logic [31:0] d, input int c);
    q2_data.push_back(64'(d)); q2_cnt.push_back(c);
  endtask

  task automatic exp4(input logic [63:0] d, input int c);
    q4_data.push_back(d); q4_cnt.push_back(c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    check("rst_rd_en2", 64'(rd_en2), 64'd0);
    check("rst_rd_en4", 64'(rd_en4), 64'd0);
    check("rst_valid2", 64'(out_valid2), 64'd0);
    check("rst_data2", 64'(out_data2), 64'd0);
    check("rst_count2", 64'(out_count2), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    reset_n = 1'b1;
    tick();

    // Streaming, PACK=2
    exp2(32'h0002_0001, 2); exp2(32'h0004_0003, 2);
    push2(16'h0001, 1'b0);
    push2(16'h0002, 1'b0);
    check("stream_latency_valid", 64'(out_valid2), 64'd1);
    check("stream_latency_data", 64'(out_data2), 64'h0002_0001);
    check("stream_rd_en", 64'(rd_en2), 64'd1);
    push2(16'h0003, 1'b0);
    push2(16'h0004, 1'b0);
    check("stream_rd_en_end", 64'(rd_en2), 64'd1);
    repeat (3) tick();

    // Backpressure, PACK=2
    exp2(32'h0002_0001, 2); exp2(32'h0004_0003, 2); exp2(32'h0006_0005, 2);
    push2(16'h0001, 1'b0);
    push2(16'h0002, 1'b0);
    out_ready2 = 1'b0;
    push2(16'h0003, 1'b0);
    check("bp_rd_en_low", 64'(rd_en2), 64'd0);
    repeat (3) tick();
    check("bp_rd_en_still_low", 64'(rd_en2), 64'd0);
    check("bp_hold_valid", 64'(out_valid2), 64'd1);
    check("bp_hold_data", 64'(out_data2), 64'h0002_0001);
    check("bp_hold_count", 64'(out_count2), 64'd2);
    out_ready2 = 1'b1;
    push2(16'h0004, 1'b0);
    push2(16'h0005, 1'b0);
    push2(16'h0006, 1'b0);
    repeat (3) tick();

    // Flush partial, PACK=4
    exp4(64'h0000_00A2_00A1_00A0, 3);
    push4(16'h00A0);
    push4(16'h00A1);
    push4(16'h00A2);
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    check("flush_rd_en_low", 64'(rd_en4), 64'd0);
    check("flush_busy", 64'(busy4), 64'd1);
    tick();
    check("flush_beat_valid", 64'(out_valid4), 64'd1);
    check("flush_beat_count", 64'(out_count4), 64'd3);
    repeat (3) tick();

    // Flush while empty, PACK=4
    flush4 = 1'b1;
    tick();
    flush4 = 1'b0;
    check("empty_flush_rd_en", 64'(rd_en4), 64'd1);
    check("empty_flush_busy", 64'(busy4), 64'd0);
    tick();
    check("empty_flush_no_beat", 64'(out_valid4), 64'd0);

    // Flush coincident with last word, PACK=2
    exp2(32'h0008_0007, 2);
    push2(16'h0007, 1'b0);
    push2(16'h0008, 1'b1);
    check("coinc_rd_en", 64'(rd_en2), 64'd1);
    repeat (3) tick();
    check("coinc_busy", 64'(busy2), 64'd0);
    check("coinc_no_extra", 64'(out_valid2), 64'd0);

    // Reset mid-fill, PACK=2
    push2(16'h0009, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_valid", 64'(out_valid2), 64'd0);
    check("midrst_busy", 64'(busy2), 64'd0);
    exp2(32'h000B_000A, 2);
    push2(16'h000A, 1'b0);
    push2(16'h000B, 1'b0);
    repeat (4) tick();

    check("p2_queue_drained", 64'(q2_data.size()), 64'd0);
    check("p4_queue_drained", 64'(q4_data.size()), 64'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
Downstream consumer of the synchronous FIFO. It drains FIFO words through the FIFO read port (rd_en/rd_valid/rd_data) and packs PACK consecutive words into one wide beat. The beat is presented on a registered valid/ready output to the next stage. A flush request forces out a partially filled beat so a tail is never stranded.

Parameters:
WIDTH, 16, width of one FIFO word (must match the FIFO WIDTH)
PACK, 2, words per output beat; legal range 2..8
CNT_BITS, $clog2(PACK+1), width of out_count

Ports:
clock  in  1  system clock; all logic on posedge
reset_n  in  1  synchronous, active-low reset
fifo_rd_en  out  1  read request to FIFO rd_en
fifo_rd_data  in  WIDTH  FIFO rd_data; valid in the same cycle as fifo_rd_valid
fifo_rd_valid  in  1  FIFO rd_valid; a word is popped this cycle
flush  in  1  single-cycle pulse; emit any partial beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat when out_valid && out_ready
out_data  out  PACK*WIDTH  packed beat; word k in bits [k*WIDTH +: WIDTH]
out_count  out  CNT_BITS  number of valid words in the beat (1..PACK)
busy  out  1  idx != 0 or flush pending or out_valid

Behaviour:
- Reset (reset_n=0 at posedge):
  - Output state: out_valid=0, out_data=0, out_count=0.
  - Internal state: idx=0, lanes=0, state=FILL.
  - fifo_rd_en is forced 0 combinationally while reset_n=0.
  - Reset mid-operation discards partial and held data; no beat is emitted.
- State:
  - idx, 0..PACK-1, counts words held in assembly lanes 0..PACK-2.
  - A single output slot holds the beat (sub-module).
- slot_free = !out_valid || out_ready. The slot can be refilled in the same cycle it is consumed.
- FSM states:
  - FILL (normal operation).
  - FLUSH (flush pending).
- FILL:
  - fifo_rd_en = (idx < PACK-1) || slot_free.
  - On fifo_rd_valid with idx < PACK-1: lanes[idx] <= fifo_rd_data; idx <= idx+1.
  - On fifo_rd_valid with idx == PACK-1 (slot_free is guaranteed):
    - out_data <= {fifo_rd_data, lanes}; out_count <= PACK; out_valid <= 1.
    - idx <= 0; lanes cleared.
  - fifo_rd_valid with fifo_rd_en=0 is a protocol error. The bench asserts it never occurs.
- Latency: a beat is visible the cycle after its last word pops. Throughput is one word per cycle while out_ready is held 1.
- flush in FILL:
  - The word popped in the flush cycle is still captured normally.
  - Next state: FLUSH if the resulting idx != 0, else stay in FILL (no beat emitted).
  - A beat completed in the flush cycle also goes out normally.
- FLUSH:
  - fifo_rd_en=0.
  - When slot_free: out_data <= lanes, with lanes >= idx zero; out_count <= idx; out_valid <= 1; idx <= 0; go to FILL.
  - flush pulses while in FLUSH are ignored.
- out_data, out_count and out_valid hold stable while out_valid && !out_ready (standard valid/ready rule).
- FIFO empty: fifo_rd_en may stay high with fifo_rd_valid=0; no state changes.
- Arithmetic:
  - idx is $clog2(PACK) bits and never exceeds PACK-1.
  - out_count of 0 is never presented with out_valid=1.

Decomposition:
- Shared package fifo_pkg:
  - Default WIDTH.
  - typedef enum logic {FILL, FLUSH} pack_state_e.
  - Function pack_count_bits(PACK).
- One sub-module fifo_out_slot: single-entry valid/ready holding register.
  - Parameter: DW.
  - Ports: load, load_data, out_valid, out_ready, slot_free.
  - fifo_rd_packer instantiates it with DW = PACK*WIDTH + CNT_BITS.

Test Plan:
- Streaming, PACK=2, WIDTH=16, out_ready=1:
  - Stimulus: FIFO supplies 16'h0001, 16'h0002, 16'h0003, 16'h0004 on consecutive cycles.
  - Response: out_data=32'h0002_0001 with count 2 one cycle after word 2; then 32'h0004_0003; fifo_rd_en stays 1 throughout.
- Backpressure:
  - Stimulus: out_ready=0 after first beat 32'h0002_0001; FIFO offers 5 words.
  - Response: exactly one more word (16'h0003) is popped, then fifo_rd_en=0; beat 1 held stable.
  - After out_ready=1: 32'h0004_0003 follows with no word lost.
- Flush partial, PACK=4:
  - Stimulus: words 16'hA0, 16'hA1, 16'hA2, then flush.
  - Response: one beat with out_data=64'h0000_00A2_00A1_00A0 and out_count=3; fifo_rd_en=0 until the beat is emitted.
- Flush while empty:
  - Stimulus: flush with idx=0 and no pop.
  - Response: no beat; state stays FILL; busy=0.
- Flush coincident with last word, PACK=2:
  - Stimulus: flush in the same cycle as word 2 pops.
  - Response: single full beat, count 2; no extra empty beat.
- Reset mid-fill:
  - Stimulus: reset_n=0 for 1 cycle after 1 word captured.
  - Response: out_valid=0, busy=0; the next two words form a clean beat with count 2.
